multiplier: RTL
===============

// Module: multiplier
// PURPOSE
//  Iterative shift-add multiplier for the RV32M MUL/MULH/MULHSU/MULHU ops.
//  Sits in EX beside the divider and reuses its stall contract.
//  EX_alu_busy is combinational, so the pipeline holds ID/EX while a product is computed.
//  Result is valid on the first cycle busy is low.
// PARAMETERS
//  WIDTH           32  operand width; product is 2*WIDTH internally
//  BITS_PER_CYCLE  1   multiplier bits retired per cycle; allowed values 1, 2, 4
//                      (must divide WIDTH)
// PORTS
//  clk             in   1      clock, rising edge
//  rst             in   1      reset, asynchronous, active-low
//  opa             in   WIDTH  multiplicand (rs1)
//  opb             in   WIDTH  multiplier (rs2)
//  ID_EX_alu_func  in   5      ALU op code (`ALU_MUL/`ALU_MULH/`ALU_MULHSU/`ALU_MULHU, sys_defs.vh)
//  product         out  WIDTH  MUL: low half of product; MULH*: high half
//  EX_alu_busy     out  1      1 = result not ready, stall EX
// BEHAVIOUR
//  Definitions
//  - mul_op: ID_EX_alu_func is one of the four MUL codes.
//  - Tag registers: a_q, b_q, f_q, tag_v. match = tag_v && {opa,opb,func}=={a_q,b_q,f_q}.
//  - FSM states: IDLE, RUN, DONE.
//  Reset (rst=0, async)
//  - state=IDLE, tag_v=0, product=0, counter=0, accumulators=0.
//  - Reset mid-RUN aborts the operation; no partial result is exposed.
//  Start
//  - Any state with mul_op && !match: next cycle is LOAD.
//    - Capture the tag and set tag_v=1.
//    - Load magnitudes |opa| and |opb|, using the signedness rules below.
//    - Record neg = sign_a ^ sign_b.
//    - Clear the 2W accumulator; cnt=WIDTH/BITS_PER_CYCLE; state=RUN.
//  - Operand or func change during RUN or DONE restarts the operation (same LOAD).
//    The old result is dropped.
//  Signedness
//  - MUL, MULH: both operands signed.
//  - MULHSU: opa signed, opb unsigned.
//  - MULHU: both operands unsigned.
//  - MUL low half is identical for signed and unsigned; it is computed as signed.
//  RUN
//  - Each cycle: acc += mcand * mplier[BITS_PER_CYCLE-1:0] (shifted);
//    mplier >>= BITS_PER_CYCLE; cnt--.
//  - When cnt reaches 0: final = neg ? -acc : acc (2W-bit two's complement);
//    product <= f_q==`ALU_MUL ? final[W-1:0] : final[2W-1:W]; state=DONE.
//  - No early termination. Fixed latency = WIDTH/BITS_PER_CYCLE + 1 cycles
//    from operand presentation to busy low (33 at defaults).
//  Busy
//  - EX_alu_busy = mul_op && !(state==DONE && match).
//  - Non-mul func: busy=0 always.
//  Non-mul func during RUN
//  - Aborts: state=IDLE, tag_v=0, product holds (flush case).
//  Repeated identical op
//  - An identical mul op immediately after DONE (same opa/opb/func) is not recomputed.
//    busy=0 in that cycle and product is reused; the value is correct.
//  Edge cases
//  - Zero operands and the most-negative value are handled with no special case:
//    0x80000000 magnitude = 2^31 fits unsigned W.
//  - All negation is done at 2W width.
//  - product changes only on RUN completion or on reset.
// TESTING
//  1. MUL 7*6: busy=1 for 33 cycles -> product=0x0000002A, busy=0.
//  2. MULH 0xFFFFFFFF*0xFFFFFFFF -> 0x00000000; MUL on same operands -> 0x00000001.
//  3. MULHSU 0xFFFFFFFF*0xFFFFFFFF -> 0xFFFFFFFF;
//     MULHU on same operands -> 0xFFFFFFFE.
//  4. MULH 0x80000000*0x80000000 -> 0x40000000;
//     MUL 0x80000000*0x00000002 -> 0x00000000.
//  5. Change opb at cycle 10 of RUN -> restart: busy stays high 33 cycles from change;
//     result matches new operands.
//  6. Assert rst low mid-RUN -> product=0 and state=IDLE immediately (async).
//     After release with func=ADD, busy=0.
//     Re-issue MUL -> full 33-cycle latency.

Source files
------------

// File: rtl/multiplier.sv
// ----------------------------------------------------------------------------
// multiplier
// Iterative shift-add multiplier for the RV32M MUL/MULH/MULHSU/MULHU ops.
// It sits in EX beside the divider and uses the same stall contract.
// EX_alu_busy is combinational, so the pipeline holds ID/EX until the result
// is ready. The result is valid on the first cycle busy is low.
//
// Ports
//   clk             in   1      clock, rising edge
//   rst             in   1      asynchronous reset, active low
//   opa             in   WIDTH  multiplicand (rs1)
//   opb             in   WIDTH  multiplier (rs2)
//   ID_EX_alu_func  in   5      ALU op code
//   product         out  WIDTH  MUL: low half of product; MULH*: high half
//   EX_alu_busy     out  1      1 = result not ready, stall EX
//
// BITS_PER_CYCLE must be 1, 2 or 4 and must divide WIDTH.
// ----------------------------------------------------------------------------
module multiplier #(
    parameter int WIDTH          = 32,
    parameter int BITS_PER_CYCLE = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] opa,
    input  logic [WIDTH-1:0] opb,
    input  logic [4:0]       ID_EX_alu_func,
    output logic [WIDTH-1:0] product,
    output logic             EX_alu_busy
);

    // ALU op codes shared with the rest of the EX stage
    localparam logic [4:0] ALU_MUL    = 5'h0B;
    localparam logic [4:0] ALU_MULH   = 5'h0C;
    localparam logic [4:0] ALU_MULHSU = 5'h0D;
    localparam logic [4:0] ALU_MULHU  = 5'h0E;

    localparam int STEPS = WIDTH / BITS_PER_CYCLE;
    localparam int CNT_W = $clog2(STEPS + 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t               state;
    logic [WIDTH-1:0]     a_q;
    logic [WIDTH-1:0]     b_q;
    logic [4:0]           f_q;
    logic                 tag_v;
    logic                 neg;
    logic [CNT_W-1:0]     cnt;
    logic [2*WIDTH-1:0]   acc;
    logic [2*WIDTH-1:0]   mcand;
    logic [WIDTH-1:0]     mplier;

    logic                 mul_op;
    logic                 match;
    logic                 sign_a;
    logic                 sign_b;
    logic [WIDTH-1:0]     mag_a;
    logic [WIDTH-1:0]     mag_b;
    logic [2*WIDTH-1:0]   partial;
    logic [2*WIDTH-1:0]   acc_sum;
    logic [2*WIDTH-1:0]   final_val;

    // Decode the op and build the magnitudes and the partial product.
    // opa is signed for every op except MULHU; opb is signed only for MUL and MULH.
    // The most-negative value negates to itself, which is exactly 2^(W-1)
    // when read as unsigned, so it needs no special case.
    always_comb begin
        mul_op = (ID_EX_alu_func == ALU_MUL)    || (ID_EX_alu_func == ALU_MULH) ||
                 (ID_EX_alu_func == ALU_MULHSU) || (ID_EX_alu_func == ALU_MULHU);
        match  = tag_v && (opa == a_q) && (opb == b_q) && (ID_EX_alu_func == f_q);
        sign_a = opa[WIDTH-1] && (ID_EX_alu_func != ALU_MULHU);
        sign_b = opb[WIDTH-1] && ((ID_EX_alu_func == ALU_MUL) || (ID_EX_alu_func == ALU_MULH));
        mag_a  = sign_a ? (~opa + 1'b1) : opa;
        mag_b  = sign_b ? (~opb + 1'b1) : opb;

        partial = '0;
        for (int i = 0; i < BITS_PER_CYCLE; i++) begin
            if (mplier[i]) begin
                partial = partial + (mcand << i);
            end
        end
        acc_sum   = acc + partial;
        // The sign is applied at 2W width, so the high half is correct too
        final_val = neg ? (~acc_sum + 1'b1) : acc_sum;
    end

    // The stall is released only when the held result belongs to the op in ID/EX
    always_comb begin
        EX_alu_busy = mul_op && !((state == DONE) && match);
    end

    // Control FSM and datapath.
    // A non-mul op aborts a running computation but keeps a finished result.
    // Any new mul op (or an operand change) reloads.
    // A running op retires BITS_PER_CYCLE multiplier bits per cycle and writes
    // product on its last step.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            f_q     <= '0;
            tag_v   <= 1'b0;
            neg     <= 1'b0;
            cnt     <= '0;
            acc     <= '0;
            mcand   <= '0;
            mplier  <= '0;
            product <= '0;
        end else if (!mul_op) begin
            if (state == RUN) begin
                state <= IDLE;
                tag_v <= 1'b0;
            end
        end else if (!match) begin
            a_q    <= opa;
            b_q    <= opb;
            f_q    <= ID_EX_alu_func;
            tag_v  <= 1'b1;
            neg    <= sign_a ^ sign_b;
            acc    <= '0;
            mcand  <= {{WIDTH{1'b0}}, mag_a};
            mplier <= mag_b;
            cnt    <= CNT_W'(STEPS);
            state  <= RUN;
        end else if (state == RUN) begin
            acc    <= acc_sum;
            mcand  <= mcand << BITS_PER_CYCLE;
            mplier <= mplier >> BITS_PER_CYCLE;
            cnt    <= cnt - CNT_W'(1);
            if (cnt == CNT_W'(1)) begin
                product <= (f_q == ALU_MUL) ? final_val[WIDTH-1:0]
                                            : final_val[2*WIDTH-1:WIDTH];
                state   <= DONE;
            end
        end
    end

endmodule
